spi_cmd_regfile: RTL and testbench

- Command decoder and control register file sitting directly downstream of the SPI slave frame receiver inside tt_um_sobel_gcd_unal.
- Consumes reassembled 16-bit host words (opcode [15:8], argument [7:0]) already synchronized into the clk_i domain.
- Drives ADC enable, channel count and calibration control into the acquisition/Sobel-GCD datapath.
- Sequences calibration with a start/done handshake and prepares the 16-bit response word shifted out on the next transfer.

---
 rtl/sobel_gcd_unal_pkg.sv | 27 ++
 rtl/spi_cmd_regfile.sv | 194 +++++++++++++++++++
 tb/tb_spi_cmd_regfile.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_gcd_unal_pkg.sv
// Shared opcodes, response headers and state encodings for the SPI command
// path of tt_um_sobel_gcd_unal.
package sobel_gcd_unal_pkg;

  localparam logic [7:0] OP_ADC_EN  = 8'h10;
  localparam logic [7:0] OP_ADC_DIS = 8'h11;
  localparam logic [7:0] OP_CALIB   = 8'h12;
  localparam logic [7:0] OP_CHAN    = 8'h13;
  localparam logic [7:0] OP_READ    = 8'h20;

  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_READ = 8'h5A;
  localparam logic [7:0] RSP_REJ  = 8'hEE;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_CHAN   = 2'd1;
  localparam logic [1:0] REG_ERR    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_CAL_WAIT = 1'b1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_regfile.sv
// Decodes host command words into control registers, sequences calibration
// and prepares the response word for the next SPI transfer.
module spi_cmd_regfile
  import sobel_gcd_unal_pkg::*;
#(
  parameter int         CAL_TIMEOUT = 4096,
  parameter int         CHAN_W      = 3,
  parameter logic [7:0] ACK_CODE    = RSP_ACK
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [15:0]       rx_word_i,
  input  logic              rx_valid_i,
  input  logic              calib_done_i,
  output logic              adc_en_o,
  output logic              calib_en_o,
  output logic              calib_start_o,
  output logic              calib_abort_o,
  output logic [CHAN_W-1:0] chan_last_o,
  output logic [15:0]       tx_word_o,
  output logic              tx_load_o,
  output logic              busy_o,
  output logic [7:0]        err_cnt_o
);

  localparam int TW = (CAL_TIMEOUT > 1) ? $clog2(CAL_TIMEOUT) : 1;

  logic [0:0]        state_q, state_d;
  logic              adc_en_q, adc_en_d, calib_en_q, calib_en_d;
  logic [CHAN_W-1:0] chan_last_q, chan_last_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [15:0]       tx_word_q, tx_word_d;
  logic              tx_load_q, tx_load_d, start_q, start_d, abort_q, abort_d;
  logic              timeout_q, timeout_d, ovf_q, ovf_d;
  logic              pend_valid_q, pend_valid_d;
  logic [15:0]       pend_word_q, pend_word_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [15:0] dec_word;
  logic [7:0]  op, arg, rd_data;
  logic        abort_word, tmo_set, ovf_set, rd_clr;
  logic        unused_arg_bits;

  // A held word takes precedence over the live strobe once back in IDLE.
  assign dec_word        = (state_q == ST_IDLE && pend_valid_q) ? pend_word_q : rx_word_i;
  assign op              = dec_word[15:8];
  assign arg             = dec_word[7:0];
  assign abort_word      = rx_valid_i && op == OP_CALIB && !arg[0];
  assign unused_arg_bits = ^arg[7:CHAN_W];

  // Control readback reports the stored ADC enable, not the busy-masked output.
  always_comb begin
    rd_data = 8'h00;
    case (arg[1:0])
      REG_CTRL: rd_data = {6'b0, calib_en_q, adc_en_q};
      REG_CHAN: rd_data = 8'(chan_last_q);
      REG_ERR:  rd_data = err_cnt_q;
      default:  rd_data = {5'b0, ovf_q, timeout_q, state_q == ST_CAL_WAIT};
    endcase
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    adc_en_d     = adc_en_q;
    calib_en_d   = calib_en_q;
    chan_last_d  = chan_last_q;
    err_cnt_d    = err_cnt_q;
    tx_word_d    = tx_word_q;
    tx_load_d    = 1'b0;
    start_d      = 1'b0;
    abort_d      = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    tmo_cnt_d    = tmo_cnt_q;
    tmo_set      = 1'b0;
    ovf_set      = 1'b0;
    rd_clr       = 1'b0;

    if (state_q == ST_IDLE) begin
      if (pend_valid_q) begin
        pend_valid_d = rx_valid_i;
        if (rx_valid_i) pend_word_d = rx_word_i;
      end
      if (pend_valid_q || rx_valid_i) begin
        tx_load_d = 1'b1;
        tx_word_d = {ACK_CODE, op};
        case (op)
          OP_ADC_EN:  adc_en_d = 1'b1;
          OP_ADC_DIS: adc_en_d = 1'b0;
          OP_CALIB: begin
            calib_en_d = arg[0];
            if (arg[0]) begin
              start_d   = 1'b1;
              state_d   = ST_CAL_WAIT;
              tmo_cnt_d = '0;
            end
          end
          OP_CHAN: chan_last_d = arg[CHAN_W-1:0];
          OP_READ: begin
            tx_word_d = {RSP_READ, rd_data};
            rd_clr    = (arg[1:0] == REG_STATUS);
          end
          default: begin
            tx_word_d = {RSP_REJ, op};
            err_cnt_d = sat_inc(err_cnt_q);
          end
        endcase
      end
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      if (rx_valid_i) begin
        tx_load_d = 1'b1;
        if (op == OP_READ) begin
          tx_word_d = {RSP_READ, rd_data};
          rd_clr    = (arg[1:0] == REG_STATUS);
        end else if (abort_word) begin
          tx_word_d  = {ACK_CODE, op};
          calib_en_d = 1'b0;
        end else if (!pend_valid_q) begin
          tx_load_d    = 1'b0;
          pend_valid_d = 1'b1;
          pend_word_d  = rx_word_i;
        end else begin
          tx_word_d = {RSP_REJ, op};
          err_cnt_d = sat_inc(err_cnt_q);
          ovf_set   = 1'b1;
        end
      end
      // Done wins: a coincident abort word then only clears calib_en, no pulse.
      if (calib_done_i) begin
        state_d = ST_IDLE;
      end else if (abort_word) begin
        abort_d = 1'b1;
        state_d = ST_IDLE;
      end else if (tmo_cnt_q == TW'(CAL_TIMEOUT - 1)) begin
        abort_d    = 1'b1;
        tmo_set    = 1'b1;
        calib_en_d = 1'b0;
        state_d    = ST_IDLE;
      end
    end

    // A fresh event beats a same-cycle read-to-clear.
    timeout_d = tmo_set | (timeout_q & ~rd_clr);
    ovf_d     = ovf_set | (ovf_q & ~rd_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      adc_en_q     <= 1'b0;
      calib_en_q   <= 1'b0;
      chan_last_q  <= '0;
      err_cnt_q    <= 8'h00;
      tx_word_q    <= 16'h0000;
      tx_load_q    <= 1'b0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      timeout_q    <= 1'b0;
      ovf_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= 16'h0000;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      adc_en_q     <= adc_en_d;
      calib_en_q   <= calib_en_d;
      chan_last_q  <= chan_last_d;
      err_cnt_q    <= err_cnt_d;
      tx_word_q    <= tx_word_d;
      tx_load_q    <= tx_load_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      timeout_q    <= timeout_d;
      ovf_q        <= ovf_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign busy_o        = (state_q == ST_CAL_WAIT);
  assign adc_en_o      = adc_en_q & ~busy_o;
  assign calib_en_o    = calib_en_q;
  assign calib_start_o = start_q;
  assign calib_abort_o = abort_q;
  assign chan_last_o   = chan_last_q;
  assign tx_word_o     = tx_word_q;
  assign tx_load_o     = tx_load_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_spi_cmd_regfile;

  localparam int CAL_TIMEOUT = 4096;
  localparam int CHAN_W      = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rx_word = 16'h0000;
  logic        rx_valid = 1'b0;
  logic        calib_done = 1'b0;

  logic              adc_en, calib_en, calib_start, calib_abort;
  logic [CHAN_W-1:0] chan_last;
  logic [15:0]       tx_word;
  logic              tx_load, busy;
  logic [7:0]        err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_cmd_regfile #(
    .CAL_TIMEOUT(CAL_TIMEOUT),
    .CHAN_W     (CHAN_W),
    .ACK_CODE   (8'hA5)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .rx_word_i    (rx_word),
    .rx_valid_i   (rx_valid),
    .calib_done_i (calib_done),
    .adc_en_o     (adc_en),
    .calib_en_o   (calib_en),
    .calib_start_o(calib_start),
    .calib_abort_o(calib_abort),
    .chan_last_o  (chan_last),
    .tx_word_o    (tx_word),
    .tx_load_o    (tx_load),
    .busy_o       (busy),
    .err_cnt_o    (err_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_cal = 0, m_adc = 0, m_cal_en = 0;
  bit          m_start = 0, m_abort = 0, m_load = 0, m_tmo = 0, m_ovf = 0;
  int          m_chan = 0, m_err = 0, m_cycles = 0;
  logic [15:0] m_tx = 16'h0000;
  logic [15:0] m_pend[$];

  function automatic logic [7:0] m_reg(input int idx);
    case (idx)
      0:       return {6'd0, m_cal_en, m_adc};
      1:       return 8'(m_chan);
      2:       return 8'(m_err);
      default: return {5'd0, m_ovf, m_tmo, m_cal};
    endcase
  endfunction

  task automatic m_read(input int idx);
    m_tx   = {8'h5A, m_reg(idx)};
    m_load = 1;
    if (idx == 3) begin
      m_tmo = 0;
      m_ovf = 0;
    end
  endtask

  task automatic m_reject(input logic [7:0] op);
    m_tx   = {8'hEE, op};
    m_load = 1;
    if (m_err < 255) m_err++;
  endtask

  task automatic m_exec(input logic [15:0] w);
    logic [7:0] op, arg;
    op  = w[15:8];
    arg = w[7:0];
    m_tx   = {8'hA5, op};
    m_load = 1;
    case (op)
      8'h10: m_adc = 1;
      8'h11: m_adc = 0;
      8'h12: begin
        m_cal_en = arg[0];
        if (arg[0]) begin
          m_start  = 1;
          m_cal    = 1;
          m_cycles = 0;
        end
      end
      8'h13: m_chan = arg % (1 << CHAN_W);
      8'h20: m_read(arg % 4);
      default: m_reject(op);
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cal = 0; m_adc = 0; m_cal_en = 0; m_start = 0; m_abort = 0; m_load = 0;
      m_tmo = 0; m_ovf = 0; m_chan = 0; m_err = 0; m_cycles = 0; m_tx = 16'h0000;
      m_pend.delete();
    end else begin
      bit is_abort;
      m_start = 0;
      m_abort = 0;
      m_load  = 0;
      if (!m_cal) begin
        if (m_pend.size() > 0) begin
          logic [15:0] held;
          held = m_pend.pop_front();
          if (rx_valid) m_pend.push_back(rx_word);
          m_exec(held);
        end else if (rx_valid) begin
          m_exec(rx_word);
        end
      end else begin
        m_cycles++;
        is_abort = rx_valid && rx_word[15:8] == 8'h12 && !rx_word[0];
        if (rx_valid && rx_word[15:8] == 8'h20) begin
          m_read(rx_word[1:0]);
        end else if (is_abort) begin
          m_tx = {8'hA5, 8'h12}; m_load = 1; m_cal_en = 0;
        end else if (rx_valid) begin
          if (m_pend.size() == 0) m_pend.push_back(rx_word);
          else begin
            m_ovf = 1;
            m_reject(rx_word[15:8]);
          end
        end
        if (calib_done) m_cal = 0;
        else if (is_abort) begin
          m_abort = 1; m_cal = 0;
        end else if (m_cycles == CAL_TIMEOUT) begin
          m_abort = 1; m_tmo = 1; m_cal_en = 0; m_cal = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("adc_en_o",      adc_en,      32'(m_adc && !m_cal));
      check("calib_en_o",    calib_en,    32'(m_cal_en));
      check("calib_start_o", calib_start, 32'(m_start));
      check("calib_abort_o", calib_abort, 32'(m_abort));
      check("chan_last_o",   chan_last,   32'(m_chan));
      check("tx_word_o",     tx_word,     32'(m_tx));
      check("tx_load_o",     tx_load,     32'(m_load));
      check("busy_o",        busy,        32'(m_cal));
      check("err_cnt_o",     err_cnt,     32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [15:0] w);
    @(posedge clk); #1;
    rx_word  = w;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    calib_done = 1'b1;
    @(posedge clk); #1;
    calib_done = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [7:0] a;
    a = 8'($urandom);
    case ($urandom % 8)
      0:       return {8'h10, a};
      1:       return {8'h11, a};
      2, 7:    return {8'h12, 8'($urandom % 2)};
      3:       return {8'h13, a};
      4, 5:    return {8'h20, a};
      default: return {8'($urandom_range(8'h30, 8'h3F)), a};
    endcase
  endfunction

  task automatic check_all_reset(input string tag);
    check({tag, "_adc"},   adc_en,      0);
    check({tag, "_cal"},   calib_en,    0);
    check({tag, "_start"}, calib_start, 0);
    check({tag, "_abort"}, calib_abort, 0);
    check({tag, "_chan"},  chan_last,   0);
    check({tag, "_tx"},    tx_word,     0);
    check({tag, "_load"},  tx_load,     0);
    check({tag, "_busy"},  busy,        0);
    check({tag, "_err"},   err_cnt,     0);
  endtask

  initial begin
    int seen;

    @(posedge clk); #1;
    check_all_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    send(16'h1001);
    check("adc_on", adc_en, 1);
    check("ack_1001", tx_word, 16'hA510);
    check("load_1001", tx_load, 1);
    @(posedge clk); #1;
    check("load_single", tx_load, 0);
    send(16'h1101);
    check("adc_off", adc_en, 0);
    check("ack_1101", tx_word, 16'hA511);

    send(16'h1307);
    send(16'h2001);
    check("chan_7", chan_last, 7);
    check("read_chan", tx_word, 16'h5A07);
    send(16'h13FA);
    check("chan_trunc", chan_last, 2);

    send(16'h1001);
    send(16'h1201);
    check("cal_start", calib_start, 1);
    check("cal_busy", busy, 1);
    check("cal_adc_mask", adc_en, 0);
    @(posedge clk); #1;
    check("cal_start_single", calib_start, 0);
    repeat (50) @(posedge clk);
    pulse_done();
    check("done_busy", busy, 0);
    check("done_adc", adc_en, 1);
    check("done_cal_en", calib_en, 1);

    send(16'h1201);
    seen = -1;
    for (int k = 1; k <= CAL_TIMEOUT + 64; k++) begin
      @(posedge clk); #1;
      if (calib_abort) begin
        seen = k;
        break;
      end
    end
    check("timeout_latency", seen, CAL_TIMEOUT);
    check("timeout_cal_en", calib_en, 0);
    send(16'h2003);
    check("status_timeout", tx_word, 16'h5A02);
    send(16'h2003);
    check("status_cleared", tx_word, 16'h5A00);

    send(16'h1201);
    send(16'h1305);
    send(16'h1001);
    check("ovf_err", err_cnt, 1);
    send(16'h2003);
    check("status_ovf", tx_word, 16'h5A05);
    pulse_done();
    @(posedge clk); #1;
    check("pend_chan", chan_last, 5);
    check("pend_ack", tx_word, 16'hA513);
    check("pend_adc", adc_en, 1);

    for (int i = 0; i < 300; i++) begin
      send(16'h7700);
      if (tx_word !== 16'hEE77) check("reject_word", tx_word, 16'hEE77);
    end
    check("reject_word_last", tx_word, 16'hEE77);
    check("err_sat", err_cnt, 255);
    send(16'h2002);
    check("read_err", tx_word, 16'h5AFF);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rx_valid   = ($urandom % 3) == 0;
      rx_word    = rand_word();
      calib_done = busy ? (($urandom % 24) == 0) : (($urandom % 4) == 0);
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
    calib_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    calib_done = 1'b0;
    repeat (3) @(posedge clk);

    send(16'h1201);
    check("pre_reset_busy", busy, 1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_reset("midcal");
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_no_abort", calib_abort, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_abort", calib_abort, 0);
    check("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
